// File: rtl/chdr_len_enforcer.sv
// CHDR length enforcer: forwards host CHDR packets whose length field is sane,
// padding runts, truncating overlong packets and dropping bad headers.
module chdr_len_enforcer #(
  parameter int MTU = 10
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic        clear,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [15:0] drop_cnt,
  output logic [15:0] pad_cnt,
  output logic [15:0] trunc_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    PAD,
    DROP
  } state_t;

  // len is 16 bits, so any MTU of 13 or more admits every length
  localparam logic [16:0] MAX_LEN =
    (MTU >= 13) ? 17'd65535 : 17'(8 << MTU);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [15:0] n_q;
  logic [15:0] n_nxt;
  logic [15:0] drop_q;
  logic [15:0] pad_q;
  logic [15:0] trunc_q;
  logic        ev_drop;
  logic        ev_pad;
  logic        ev_trunc;

  logic [1:0]  rst_sr;
  logic        rst_i;

  logic [16:0] len_ext;
  logic [16:0] len_rnd;
  logic [15:0] n_hdr;
  logic        hdr_ok;
  logic        hdr_one;
  logic        last_beat;

  logic [63:0] o_dat;
  logic        o_vld;
  logic        o_last;
  logic        i_rdy;
  logic        i_xfer;
  logic        o_xfer;

  // assert with bus_rst, release two edges later in bus_clk domain
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) rst_sr <= 2'b11;
    else         rst_sr <= {rst_sr[0], 1'b0};
  end

  assign rst_i = rst_sr[1];

  assign len_ext   = {1'b0, i_tdata[15:0]};
  assign len_rnd   = len_ext + 17'd7;
  assign n_hdr     = {2'b00, len_rnd[16:3]};
  assign hdr_ok    = (len_ext >= 17'd8) && (len_ext <= MAX_LEN);
  assign hdr_one   = (n_hdr == 16'd1);
  assign last_beat = (cnt == n_q - 16'd1);

  assign o_tdata  = o_dat;
  assign o_tvalid = o_vld & ~rst_i;
  assign o_tlast  = o_last & ~rst_i;
  assign i_tready = i_rdy & ~rst_i;

  assign i_xfer = i_tvalid & i_tready;
  assign o_xfer = o_tvalid & o_tready;

  always_ff @(posedge bus_clk or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      n_q   <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      n_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      n_q   <= n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_nxt     = n_q;
    ev_drop   = 1'b0;
    ev_pad    = 1'b0;
    ev_trunc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_xfer) begin
          if (!hdr_ok) begin
            ev_drop   = 1'b1;
            state_nxt = i_tlast ? IDLE : DROP;
          end else begin
            n_nxt = n_hdr;
            if (hdr_one) begin
              ev_trunc  = ~i_tlast;
              state_nxt = i_tlast ? IDLE : DROP;
            end else begin
              cnt_nxt   = 16'd1;
              state_nxt = PASS;
            end
          end
        end
      end
      PASS: begin
        if (i_xfer) begin
          if (last_beat) begin
            ev_trunc  = ~i_tlast;
            state_nxt = i_tlast ? IDLE : DROP;
          end else begin
            cnt_nxt = cnt + 16'd1;
            if (i_tlast) begin
              ev_pad    = 1'b1;
              state_nxt = PAD;
            end
          end
        end
      end
      PAD: begin
        if (o_xfer) begin
          if (last_beat) state_nxt = IDLE;
          else           cnt_nxt   = cnt + 16'd1;
        end
      end
      DROP: begin
        if (i_xfer && i_tlast) state_nxt = IDLE;
      end
    endcase
    if (state_nxt == IDLE) cnt_nxt = '0;
  end

  always_comb begin
    o_dat  = i_tdata;
    o_vld  = 1'b0;
    o_last = 1'b0;
    i_rdy  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hdr_ok) begin
          o_vld  = i_tvalid;
          i_rdy  = o_tready;
          o_last = hdr_one;
        end else begin
          i_rdy = 1'b1;
        end
      end
      PASS: begin
        o_vld  = i_tvalid;
        i_rdy  = o_tready;
        o_last = last_beat;
      end
      PAD: begin
        o_dat  = '0;
        o_vld  = 1'b1;
        o_last = last_beat;
      end
      DROP: begin
        i_rdy = 1'b1;
      end
    endcase
  end

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        en
  );
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // clear takes priority over any event in the same cycle
  always_ff @(posedge bus_clk or posedge rst_i) begin
    if (rst_i) begin
      drop_q  <= '0;
      pad_q   <= '0;
      trunc_q <= '0;
    end else if (clear) begin
      drop_q  <= '0;
      pad_q   <= '0;
      trunc_q <= '0;
    end else begin
      drop_q  <= sat_inc(drop_q, ev_drop);
      pad_q   <= sat_inc(pad_q, ev_pad);
      trunc_q <= sat_inc(trunc_q, ev_trunc);
    end
  end

  assign drop_cnt  = drop_q;
  assign pad_cnt   = pad_q;
  assign trunc_cnt = trunc_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_chdr_len_enforcer.sv
// Self-checking bench for chdr_len_enforcer: packet table with an output
// scoreboard, plus hand-written reset, clear and saturation sequences.
module tb_chdr_len_enforcer;

  logic        bus_clk;
  logic        bus_rst;
  logic        clear;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [15:0] drop_cnt;
  logic [15:0] pad_cnt;
  logic [15:0] trunc_cnt;
  logic        busy;

  chdr_len_enforcer #(.MTU(10)) dut (
    .bus_clk   (bus_clk),
    .bus_rst   (bus_rst),
    .clear     (clear),
    .i_tdata   (i_tdata),
    .i_tlast   (i_tlast),
    .i_tvalid  (i_tvalid),
    .i_tready  (i_tready),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .drop_cnt  (drop_cnt),
    .pad_cnt   (pad_cnt),
    .trunc_cnt (trunc_cnt),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] len;
    int          nin;
    int          nfwd;
    int          npad;
    int          dd;
    int          dp;
    int          dt;
    bit          bp;
  } vec_t;

  vec_t        vecs[14];
  logic [64:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 0;
  bit          bp_en = 0;
  bit          stall_prev = 0;
  logic [63:0] prev_data;
  logic        prev_last;
  logic [15:0] e_drop = 0;
  logic [15:0] e_pad = 0;
  logic [15:0] e_trunc = 0;

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  always @(posedge bus_clk) begin
    #1;
    o_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] bdata(input logic [15:0] len,
                                        input int k, input int tag);
    if (k == 0) return {16'(tag), 32'hFEED_F00D, len};
    return {16'(tag), 16'(k), 32'h5A5A_0000 | 32'(k)};
  endfunction

  always @(negedge bus_clk) begin
    logic [64:0] e;
    if (mon_en) begin
      if (stall_prev) begin
        chk("stall_valid", 64'(o_tvalid), 64'd1);
        chk("stall_data", o_tdata, prev_data);
        chk("stall_last", 64'(o_tlast), 64'(prev_last));
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h want none", o_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", o_tdata, e[63:0]);
          chk("out_last", 64'(o_tlast), 64'(e[64]));
        end
      end
      stall_prev = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send_pkt(input logic [15:0] len, input int nin,
                          input int tag);
    int   t;
    logic acc;
    for (int k = 0; k < nin; k++) begin
      i_tdata  = bdata(len, k, tag);
      i_tlast  = (k == nin - 1);
      i_tvalid = 1'b1;
      t = 0;
      forever begin
        @(negedge bus_clk);
        acc = i_tready;
        @(posedge bus_clk);
        #1;
        if (acc) break;
        t++;
        if (t > 500) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout: got stalled %0d cycles want accept", t);
          break;
        end
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge bus_clk);
      t++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge bus_clk);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(e_drop));
    chk({tag, "_pad"}, 64'(pad_cnt), 64'(e_pad));
    chk({tag, "_trunc"}, 64'(trunc_cnt), 64'(e_trunc));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int nsat;
    vecs[0]  = '{16'd24,   3,    3,    0, 0, 0, 0, 1'b0};
    vecs[1]  = '{16'd40,   2,    2,    3, 0, 1, 0, 1'b0};
    vecs[2]  = '{16'd16,   4,    2,    0, 0, 0, 1, 1'b0};
    vecs[3]  = '{16'd4,    3,    0,    0, 1, 0, 0, 1'b0};
    vecs[4]  = '{16'd8200, 3,    0,    0, 1, 0, 0, 1'b0};
    vecs[5]  = '{16'd8,    1,    1,    0, 0, 0, 0, 1'b0};
    vecs[6]  = '{16'd8,    3,    1,    0, 0, 0, 1, 1'b0};
    vecs[7]  = '{16'd9,    2,    2,    0, 0, 0, 0, 1'b0};
    vecs[8]  = '{16'd8192, 1024, 1024, 0, 0, 0, 0, 1'b1};
    vecs[9]  = '{16'd7,    1,    0,    0, 1, 0, 0, 1'b0};
    vecs[10] = '{16'd8193, 1,    0,    0, 1, 0, 0, 1'b0};
    vecs[11] = '{16'd33,   2,    2,    3, 0, 1, 0, 1'b1};
    vecs[12] = '{16'd64,   8,    8,    0, 0, 0, 0, 1'b1};
    vecs[13] = '{16'd0,    2,    0,    0, 1, 0, 0, 1'b0};

    bus_rst  = 1'b1;
    clear    = 1'b0;
    o_tready = 1'b1;
    i_tdata  = bdata(16'd8, 0, 0);
    i_tlast  = 1'b1;
    i_tvalid = 1'b1;
    repeat (3) @(posedge bus_clk);
    @(negedge bus_clk);
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_o_tlast", 64'(o_tlast), 64'd0);
    chk("rst_i_tready", 64'(i_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    check_cnts("rst");
    i_tvalid = 1'b0;
    bus_rst  = 1'b0;
    repeat (3) @(posedge bus_clk);
    #1;
    mon_en = 1'b1;

    for (int v = 0; v < 14; v++) begin
      for (int j = 0; j < vecs[v].nfwd + vecs[v].npad; j++) begin
        logic        lst;
        logic [63:0] d;
        lst = (j == vecs[v].nfwd + vecs[v].npad - 1);
        d   = (j < vecs[v].nfwd) ? bdata(vecs[v].len, j, v) : 64'd0;
        exp_q.push_back({lst, d});
      end
      bp_en = vecs[v].bp;
      send_pkt(vecs[v].len, vecs[v].nin, v);
      if (vecs[v].npad > 0 && !vecs[v].bp)
        chk("pad_i_tready", 64'(i_tready), 64'd0);
      drain();
      bp_en = 1'b0;
      e_drop  = e_drop + 16'(vecs[v].dd);
      e_pad   = e_pad + 16'(vecs[v].dp);
      e_trunc = e_trunc + 16'(vecs[v].dt);
      check_cnts($sformatf("vec%0d", v));
    end

    nsat = 65535 - int'(e_drop);
    for (int k = 0; k < nsat; k++) send_pkt(16'd0, 1, 99);
    repeat (2) @(posedge bus_clk);
    #1;
    chk("sat_reach", 64'(drop_cnt), 64'hFFFF);
    send_pkt(16'd3, 1, 98);
    repeat (2) @(posedge bus_clk);
    #1;
    chk("sat_hold", 64'(drop_cnt), 64'hFFFF);

    clear = 1'b1;
    @(posedge bus_clk);
    #1;
    clear = 1'b0;
    e_drop  = 0;
    e_pad   = 0;
    e_trunc = 0;
    check_cnts("clear");

    mon_en   = 1'b0;
    i_tdata  = bdata(16'd24, 0, 50);
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    @(posedge bus_clk);
    #1;
    i_tdata = bdata(16'd24, 1, 50);
    chk("mid_pass_busy", 64'(busy), 64'd1);
    #1;
    bus_rst = 1'b1;
    #1;
    chk("async_rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    #1;
    bus_rst = 1'b0;
    i_tdata = bdata(16'd8, 0, 51);
    i_tlast = 1'b1;
    @(posedge bus_clk);
    @(negedge bus_clk);
    chk("post_rel_i_tready", 64'(i_tready), 64'd0);
    chk("post_rel_o_tvalid", 64'(o_tvalid), 64'd0);
    i_tvalid = 1'b0;
    repeat (3) @(posedge bus_clk);
    #1;

    i_tdata  = bdata(16'd40, 0, 52);
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    @(posedge bus_clk);
    #1;
    i_tdata = bdata(16'd40, 1, 52);
    i_tlast = 1'b1;
    clear   = 1'b1;
    @(posedge bus_clk);
    #1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    chk("clr_runt_pad", 64'(pad_cnt), 64'd0);
    chk("clr_runt_busy", 64'(busy), 64'd0);
    chk("clr_runt_o_tvalid", 64'(o_tvalid), 64'd0);
    repeat (2) @(posedge bus_clk);
    #1;

    mon_en = 1'b1;
    for (int j = 0; j < 3; j++)
      exp_q.push_back({(j == 2), bdata(16'd24, j, 53)});
    send_pkt(16'd24, 3, 53);
    drain();
    check_cnts("recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
